// File: rtl/vec_add_pkg.sv
// Shared types and constants for the vector-add scheduler.
// A vector is 16 packed bytes; the scheduler FSM has four states.
package vec_add_pkg;

    localparam int VEC_LEN = 16;
    localparam int VEC_W   = VEC_LEN * 8;

    typedef logic [7:0]               byte_t;
    typedef logic [VEC_LEN-1:0][7:0]  vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/vec_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vec_add_sched.sv
// Shares one 16x8-bit vector-add engine among NREQ requesters with
// round-robin arbitration and a WAIT-state timeout watchdog.
module vec_add_sched
    import vec_add_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*VEC_W-1:0]   req_a_i,
    input  logic [NREQ*VEC_W-1:0]   req_b_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    input  logic [NREQ-1:0]         rsp_ready_i,
    output logic [VEC_W-1:0]        rsp_result_o,
    output logic                    rsp_err_o,
    output logic                    eng_start_o,
    output logic [VEC_W-1:0]        eng_a_o,
    output logic [VEC_W-1:0]        eng_b_o,
    input  logic                    eng_busy_i,
    input  logic                    eng_done_i,
    input  logic [VEC_W-1:0]        eng_result_i,
    output logic [15:0]             ops_cnt_o
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NREQ - 1);

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    vec_t            a_q, a_d, b_q, b_d;
    vec_t            result_q, result_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     ops_q, ops_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            grant;
    logic            rsp_accept;
    logic            timed_out;
    vec_t            sel_a, sel_b;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign grant      = (state_q == IDLE) && (|req_valid_i) && !eng_busy_i;
    assign rsp_accept = (state_q == RESP) && rsp_ready_i[gidx_q];
    assign timed_out  = (timer_q == TIMER_LAST);

    // One-hot operand select for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (arb_gnt[r]) begin
                sel_a = req_a_i[r*VEC_W +: VEC_W];
                sel_b = req_b_i[r*VEC_W +: VEC_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= RSP_ERR_NONE;
            timer_q  <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            ops_q    <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (eng_done_i || timed_out) state_d = RESP;
            RESP:    if (rsp_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        timer_d  = timer_q;
        ops_d    = ops_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    gidx_d = arb_idx;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    ptr_d  = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                end
            end
            ISSUE: timer_d = '0;
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done arriving on the timeout cycle still counts as success.
                if (eng_done_i) begin
                    result_d = eng_result_i;
                    err_d    = RSP_ERR_NONE;
                end else if (timed_out) begin
                    result_d = '0;
                    err_d    = RSP_ERR_TIMEOUT;
                end
            end
            RESP: if (rsp_accept) ops_d = ops_q + 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        req_ready_o  = grant ? arb_gnt : '0;
        eng_start_o  = (state_q == ISSUE);
        rsp_valid_o  = (state_q == RESP) ? (NREQ'(1) << gidx_q) : '0;
        rsp_result_o = result_q;
        rsp_err_o    = err_q;
        eng_a_o      = a_q;
        eng_b_o      = b_q;
        ops_cnt_o    = ops_q;
    end

    // A requester must hold its request until it is accepted.
    for (genvar r = 0; r < NREQ; r++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[r] && !req_ready_o[r]) |=> req_valid_i[r]);
    end

endmodule
